// File: rtl/mem_arbiter_2x1.sv
// mem_arbiter_2x1
// Shares one zero-latency RAM (12-bit word address, 16-bit data) between two
// bus masters: port 0 (CPU) and port 1 (loader/debug master).
//
// Handshake: a port requests when mX_read | mX_write. A request is accepted
// (one access completes) in any cycle where mX_waitrequest is low. While
// mX_waitrequest is high the master must hold address/data/command stable.
// mX_waitrequest is low whenever the port is not requesting.
//
// Build option (macro ARB_ROUND_ROBIN_EN):
//   defined   - bounded-burst round robin; an owner keeps the bus for at most
//               MAX_BURST consecutive grants while the other port is waiting.
//   undefined - strict fixed priority, port 0 highest; MAX_BURST only sizes
//               the debug counter port, which then reads as zero.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m0_* / m1_*              master ports (address, read, write, writedata,
//                            readdata, waitrequest)
//   ram_*                    RAM side (address, read, write, writedata,
//                            readdata)
//   dbg_state                current FSM state (0 IDLE, 1 OWN0, 2 OWN1)
//   dbg_cnt                  current burst counter
module mem_arbiter_2x1 #(
  parameter int MAX_BURST = 4,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [11:0]   m0_address,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [15:0]   m0_writedata,
  output logic [15:0]   m0_readdata,
  output logic          m0_waitrequest,
  input  logic [11:0]   m1_address,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [15:0]   m1_writedata,
  output logic [15:0]   m1_readdata,
  output logic          m1_waitrequest,
  output logic [11:0]   ram_address,
  output logic          ram_read,
  output logic          ram_write,
  output logic [15:0]   ram_writedata,
  input  logic [15:0]   ram_readdata,
  output logic [1:0]    dbg_state,
  output logic [CW-1:0] dbg_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state;
  logic   req0, req1;
  logic   grant0, grant1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  logic [CW-1:0] cnt;
  logic          last_owner;

  // Grant decision is combinational from registered state and live requests,
  // so a handover costs no idle cycle on the RAM bus.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            // Tie goes to the port that did not own the bus last.
            if (last_owner) grant0 = 1'b1;
            else            grant1 = 1'b1;
          end else begin
            grant0 = req0;
            grant1 = req1;
          end
        end
        OWN0: begin
          if (req0 && ((cnt < MAX_CNT) || !req1)) grant0 = 1'b1;
          else                                    grant1 = req1;
        end
        OWN1: begin
          if (req1 && ((cnt < MAX_CNT) || !req0)) grant1 = 1'b1;
          else                                    grant0 = req0;
        end
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= 1'b1;
    end else if (grant0) begin
      if (state == OWN0) begin
        // Saturate rather than wrap: a lone owner may stream indefinitely.
        if (cnt != MAX_CNT) cnt <= cnt + CW'(1);
      end else begin
        cnt <= CW'(1);
        if (state == OWN1) last_owner <= 1'b1;
      end
      state <= OWN0;
    end else if (grant1) begin
      if (state == OWN1) begin
        if (cnt != MAX_CNT) cnt <= cnt + CW'(1);
      end else begin
        cnt <= CW'(1);
        if (state == OWN0) last_owner <= 1'b0;
      end
      state <= OWN1;
    end else begin
      if (state == OWN0)      last_owner <= 1'b0;
      else if (state == OWN1) last_owner <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
    end
  end

  assign dbg_cnt = cnt;
`else
  // Fixed priority: port 0 wins every cycle it requests.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      grant0 = req0;
      grant1 = req1 & ~req0;
    end
  end

  // State is kept only so the current owner is observable.
  always_ff @(posedge clk) begin
    if (rst)         state <= IDLE;
    else if (grant0) state <= OWN0;
    else if (grant1) state <= OWN1;
    else             state <= IDLE;
  end

  assign dbg_cnt = '0;
`endif

  // RAM-side mux; everything idles at zero when nobody is granted.
  always_comb begin
    ram_address   = '0;
    ram_read      = 1'b0;
    ram_write     = 1'b0;
    ram_writedata = '0;
    if (grant0) begin
      ram_address   = m0_address;
      ram_read      = m0_read;
      ram_write     = m0_write;
      ram_writedata = m0_writedata;
    end else if (grant1) begin
      ram_address   = m1_address;
      ram_read      = m1_read;
      ram_write     = m1_write;
      ram_writedata = m1_writedata;
    end
  end

  assign m0_readdata    = ram_readdata;
  assign m1_readdata    = ram_readdata;
  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;
  assign dbg_state      = state;

endmodule

// File: doc/mem_arbiter_2x1.md
# mem_arbiter_2x1

Two-port arbiter that shares the single RAM_16x4096 memory (12-bit word address, 16-bit data, zero-latency read) between two bus masters: the MU0 CPU on port 0 and a loader/debug master on port 1. It adds a `waitrequest` stall to each master port and owns the bus with a small state machine. Burst ownership is bounded, so neither master can starve the other. It sits between the masters and the RAM instance in the top-level and testbench.

## Interface
- `MAX_BURST`, 4: maximum consecutive granted accesses per owner while the other port is requesting (≥1).
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_address`  in  12  port 0 word address.
- `m0_read`  in  1  port 0 read request.
- `m0_write`  in  1  port 0 write request.
- `m0_writedata`  in  16  port 0 write data.
- `m0_readdata`  out  16  RAM read data; valid in the cycle a port 0 read is granted.
- `m0_waitrequest`  out  1  high = port 0 request not accepted this cycle; hold request stable.
- `m1_*`  same set as port 0, for port 1.
- `ram_address`  out  12  to RAM.
- `ram_read`  out  1  to RAM.
- `ram_write`  out  1  to RAM.
- `ram_writedata`  out  16  to RAM.
- `ram_readdata`  in  16  from RAM (combinational, delay0).

## Operation
- Port x is requesting when `mx_read | mx_write`. Both asserted together is forwarded unchanged; the RAM decides the result.
- State: `state` ∈ {IDLE, OWN0, OWN1}, burst counter `cnt` (saturating at MAX_BURST), `last_owner` bit.
- Grant is combinational from registered state and current requests. The granted port's address, read, write and writedata are muxed to the RAM.
- `ram_readdata` is broadcast to both `mx_readdata`. It is meaningful only to the granted reader.
- `mx_waitrequest` = requesting & ~granted. It is 0 when the port is not requesting.
- IDLE:
  - One requester: grant it; go to OWNx, `cnt`=1.
  - Both requesting: grant the port ≠ `last_owner`.
  - None requesting: stay in IDLE.
- OWNx:
  - Owner requesting and (`cnt` < MAX_BURST or other port idle): grant owner, `cnt`++ (saturating).
  - Otherwise, if the other port is requesting: grant it this same cycle, go to OWNy, `cnt`=1, `last_owner`=x. No bubble cycle.
  - No requests: go to IDLE, `last_owner`=x.
- Every grant completes exactly one access in that cycle. A master deasserting its request after a granted cycle is normal.

## Timing
- Access latency is 0 cycles when the port is granted: write reaches the RAM on the same posedge, and read data is valid in the same cycle.
- Worst-case wait for a continuously requesting port is MAX_BURST cycles.
- While `rst`=1:
  - no grants;
  - `ram_read`=`ram_write`=0, `ram_address`=0, `ram_writedata`=0;
  - `mx_waitrequest`=1 for any requesting port.
- On the posedge with `rst`=1, state is set to IDLE, `cnt`=0 and `last_owner`=1, so port 0 wins the first tie.
- Reset mid-burst aborts ownership. The in-flight request is not granted in the reset cycle and must be re-presented.
- Requests arriving in the same cycle the owner drops: the newcomer is granted that cycle.
- The `cnt` width is clog2(MAX_BURST+1). There is no wrap, only saturation.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: bounded-burst round-robin exactly as described above.
- Not defined: strict fixed priority, port 0 highest.
  - Port 0 is granted in every cycle it requests, including preempting a port 1 burst mid-stream.
  - Port 1 is granted only in cycles when port 0 is not requesting.
  - `cnt` and `last_owner` are not implemented, and MAX_BURST is ignored.
  - States reduce to IDLE/OWN0/OWN1 for observability only.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with both ports reading → `ram_read`=0 and both waitrequest=1; in the first cycle after release, port 0 is granted.
- Single master: m1 writes 0x1234 to 0x0A5 → `ram_write`=1 and `m1_waitrequest`=0 that cycle; next, m0 reads 0x0A5 → `m0_readdata`=0x1234 in the same cycle, `m0_waitrequest`=0.
- Fairness (macro on, MAX_BURST=4): both read continuously → grant sequence 0,0,0,0,1,1,1,1,0,…; no port ever waits more than 4 cycles.
- Handover: m0 owns and stops after 2 accesses while m1 has been waiting → m1 is granted in the very next cycle, with no idle cycle on the RAM bus.
- Reset mid-burst: assert `rst` during the 3rd access of an m1 burst → that cycle gets no grant; after release with both requesting → port 0 is granted, `cnt`=1.
- Fixed priority (macro off): both request for 20 cycles → m0 is granted every cycle and `m1_waitrequest`=1 throughout; m0 then drops → m1 is granted the same cycle.
